// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment driver: one digit slot per SCAN_DIV clocks, PWM duty, guard gap.
// seg/anode/frame_start lag the scan counters by one cycle; no backpressure, free-running scan.
module display_scan_mux #(
   parameter int NUM_DIGITS       = 4,
   parameter int SCAN_DIV         = 1024,
   parameter int BRIGHT_BITS      = 4,
   parameter int GUARD            = 2,
   parameter int ANODE_ACTIVE_LOW = 0,
   parameter int SEG_ACTIVE_LOW   = 0,
   localparam int IDX_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7*NUM_DIGITS-1:0] disp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [BRIGHT_BITS-1:0]  brightness,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_start
);

   localparam int PW    = $clog2(SCAN_DIV);
   localparam int SHIFT = PW - BRIGHT_BITS;

   localparam logic                  AAL     = (ANODE_ACTIVE_LOW != 0);
   localparam logic                  SAL     = (SEG_ACTIVE_LOW != 0);
   localparam logic [6:0]            SEG_OFF = {7{SAL}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AAL}};

   logic [PW-1:0]          pcnt;
   logic [6:0]             slot_pat;
   logic                   slot_blank;
   logic [BRIGHT_BITS-1:0] slot_bright;

   logic [6:0]             cur_pat;
   logic                   cur_blank;
   logic [BRIGHT_BITS-1:0] phase;
   logic                   lit;
   logic                   slot_first;
   logic                   slot_last;
   logic                   digit_last;
   logic [NUM_DIGITS-1:0]  onehot;

   always_comb begin
      cur_pat   = 7'h00;
      cur_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (digit_idx == IDX_W'(k)) begin
            cur_pat   = disp[7*k +: 7];
            cur_blank = blank[k];
         end
      end
   end

   // The top BRIGHT_BITS of the prescaler split each slot into equal PWM phases.
   assign phase      = pcnt[PW-1:SHIFT];
   assign slot_first = (pcnt == '0);
   assign slot_last  = (pcnt == PW'(SCAN_DIV - 1));
   assign digit_last = (digit_idx == IDX_W'(NUM_DIGITS - 1));
   assign onehot     = NUM_DIGITS'(1) << digit_idx;

   // GUARD >= 1 keeps pcnt==0 dark, so the slot registers are always settled when lit.
   assign lit = (pcnt >= PW'(GUARD)) && (phase < slot_bright) && !slot_blank;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt      <= '0;
         digit_idx <= '0;
      end else begin
         pcnt <= pcnt + 1'b1;
         if (slot_last) begin
            digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_pat    <= 7'h00;
         slot_blank  <= 1'b0;
         slot_bright <= '0;
      end else if (slot_first) begin
         slot_pat    <= cur_pat;
         slot_blank  <= cur_blank;
         slot_bright <= brightness;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg         <= SEG_OFF;
         anode       <= AN_OFF;
         frame_start <= 1'b0;
      end else begin
         seg         <= (lit ? slot_pat : 7'h00) ^ SEG_OFF;
         anode       <= (lit ? onehot : '0) ^ AN_OFF;
         frame_start <= slot_first && (digit_idx == '0);
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: main 4-digit instance, an active-low twin and a 3-digit variant.
module tb_display_scan_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [27:0] disp;
   logic [27:0] disp_p;
   logic [3:0]  blank;
   logic [1:0]  brightness;
   logic [6:0]  seg, seg_p;
   logic [3:0]  anode, anode_p;
   logic [1:0]  digit_idx, idx_p;
   logic        frame_start, fs_p;

   logic [20:0] disp3;
   logic [2:0]  blank3;
   logic [0:0]  bright3;
   logic [6:0]  seg3;
   logic [2:0]  anode3;
   logic [1:0]  idx3;
   logic        fs3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   display_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(16), .BRIGHT_BITS(2), .GUARD(1),
                      .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) u_main (
      .clk(clk), .rst(rst), .disp(disp), .blank(blank), .brightness(brightness),
      .seg(seg), .anode(anode), .digit_idx(digit_idx), .frame_start(frame_start));

   display_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(16), .BRIGHT_BITS(2), .GUARD(1),
                      .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) u_pol (
      .clk(clk), .rst(rst), .disp(disp_p), .blank(blank), .brightness(brightness),
      .seg(seg_p), .anode(anode_p), .digit_idx(idx_p), .frame_start(fs_p));

   display_scan_mux #(.NUM_DIGITS(3), .SCAN_DIV(8), .BRIGHT_BITS(1), .GUARD(1),
                      .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) u_three (
      .clk(clk), .rst(rst), .disp(disp3), .blank(blank3), .brightness(bright3),
      .seg(seg3), .anode(anode3), .digit_idx(idx3), .frame_start(fs3));

   // Advance one clock and sample 1 time unit after the edge; every cycle checks one-hot anodes.
   task automatic tick();
      @(posedge clk);
      #1;
      checks++;
      assert ($countones(anode) <= 1 && $countones(anode3) <= 1) else begin
         failures++;
         $display("FAIL onehot_anode: anode=%b anode3=%b, required at most one active", anode, anode3);
      end
   endtask

   task automatic sync_frame();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (frame_start) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL sync_frame: no frame_start within 200 cycles, required one pulse");
      end
   endtask

   // Called while the sample shows pcnt 0 of a slot; returns statistics for that slot's 15 lit-capable cycles.
   task automatic measure_slot(output int on_cnt, output int first_on, output int last_on,
                               output logic [3:0] an_seen, output logic [6:0] seg_seen,
                               output int fs_cnt, output int bad_dark);
      on_cnt = 0; first_on = -1; last_on = -1; an_seen = 4'h0; seg_seen = 7'h00;
      fs_cnt = 0; bad_dark = 0;
      for (int j = 1; j <= 16; j++) begin
         tick();
         if (j < 16) begin
            if (frame_start) fs_cnt++;
            if (anode != 4'h0) begin
               on_cnt++;
               if (first_on < 0) first_on = j;
               last_on  = j;
               an_seen  = anode;
               seg_seen = seg;
            end else if (seg != 7'h00) begin
               bad_dark++;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      disp       = {7'h06, 7'h5B, 7'h4F, 7'h66};
      disp_p     = {7'h06, 7'h5B, 7'h4F, 7'h3F};
      blank      = 4'b0000;
      brightness = 2'd3;
      disp3      = {7'h4F, 7'h5B, 7'h06};
      blank3     = 3'b000;
      bright3    = 1'b1;
      repeat (3) tick();
      checks++; if (seg !== 7'h00) begin failures++; $display("FAIL reset_seg: got %h, required 00", seg); end
      checks++; if (anode !== 4'b0000) begin failures++; $display("FAIL reset_anode: got %b, required 0000", anode); end
      checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs: got %b, required 0", frame_start); end
      checks++; if (digit_idx !== 2'd0) begin failures++; $display("FAIL reset_idx: got %0d, required 0", digit_idx); end
      checks++; if (anode3 !== 3'b000 || seg3 !== 7'h00) begin failures++; $display("FAIL reset_three: anode3=%b seg3=%h, required 000/00", anode3, seg3); end
      #2 rst = 1'b0;
      tick();
      checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL first_fs: got %b, required 1", frame_start); end
      checks++; if (anode !== 4'b0000) begin failures++; $display("FAIL guard_dark: got %b, required 0000", anode); end
      tick();
      checks++; if (anode !== 4'b0001 || seg !== 7'h66) begin failures++; $display("FAIL first_lit: anode=%b seg=%h, required 0001/66", anode, seg); end
      checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL fs_width: got %b, required 0", frame_start); end
   endtask

   task automatic test_scan_order();
      logic [3:0] exp_an  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [6:0] exp_seg [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
      int on_cnt, first_on, last_on, fs_cnt, bad_dark;
      logic [3:0] an_seen;
      logic [6:0] seg_seen;
      sync_frame();
      checks++; if (digit_idx !== 2'd0) begin failures++; $display("FAIL scan_idx0: got %0d, required 0", digit_idx); end
      for (int d = 0; d < 4; d++) begin
         measure_slot(on_cnt, first_on, last_on, an_seen, seg_seen, fs_cnt, bad_dark);
         checks++; if (an_seen !== exp_an[d]) begin failures++; $display("FAIL scan_anode d=%0d: got %b, required %b", d, an_seen, exp_an[d]); end
         checks++; if (seg_seen !== exp_seg[d]) begin failures++; $display("FAIL scan_seg d=%0d: got %h, required %h", d, seg_seen, exp_seg[d]); end
         checks++; if (on_cnt != 11 || first_on != 1 || last_on != 11) begin failures++; $display("FAIL duty_b3 d=%0d: on=%0d first=%0d last=%0d, required 11/1/11", d, on_cnt, first_on, last_on); end
         checks++; if (fs_cnt != 0 || bad_dark != 0) begin failures++; $display("FAIL scan_clean d=%0d: fs=%0d dark_seg=%0d, required 0/0", d, fs_cnt, bad_dark); end
      end
      checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL frame_period: got %b after 64 cycles, required 1", frame_start); end
   endtask

   task automatic test_duty();
      int on_cnt, first_on, last_on, fs_cnt, bad_dark, total;
      logic [3:0] an_seen;
      logic [6:0] seg_seen;
      sync_frame();
      brightness = 2'd1;
      measure_slot(on_cnt, first_on, last_on, an_seen, seg_seen, fs_cnt, bad_dark);
      checks++; if (on_cnt != 11) begin failures++; $display("FAIL bright_midslot: on=%0d, required 11", on_cnt); end
      measure_slot(on_cnt, first_on, last_on, an_seen, seg_seen, fs_cnt, bad_dark);
      checks++; if (on_cnt != 3 || first_on != 1 || last_on != 3) begin failures++; $display("FAIL duty_b1: on=%0d first=%0d last=%0d, required 3/1/3", on_cnt, first_on, last_on); end
      brightness = 2'd0;
      measure_slot(on_cnt, first_on, last_on, an_seen, seg_seen, fs_cnt, bad_dark);
      checks++; if (on_cnt != 3) begin failures++; $display("FAIL bright0_midslot: on=%0d, required 3", on_cnt); end
      total = 0;
      for (int d = 0; d < 4; d++) begin
         measure_slot(on_cnt, first_on, last_on, an_seen, seg_seen, fs_cnt, bad_dark);
         total += on_cnt;
      end
      checks++; if (total != 0) begin failures++; $display("FAIL duty_b0: on=%0d over a frame, required 0", total); end
      sync_frame();
   endtask

   task automatic test_blank();
      int exp_on [4] = '{11, 11, 0, 11};
      int on_cnt, first_on, last_on, fs_cnt, bad_dark;
      logic [3:0] an_seen;
      logic [6:0] seg_seen;
      brightness = 2'd3;
      blank      = 4'b0100;
      sync_frame();
      for (int d = 0; d < 4; d++) begin
         measure_slot(on_cnt, first_on, last_on, an_seen, seg_seen, fs_cnt, bad_dark);
         checks++; if (on_cnt != exp_on[d]) begin failures++; $display("FAIL blank d=%0d: on=%0d, required %0d", d, on_cnt, exp_on[d]); end
      end
      blank = 4'b0000;
   endtask

   task automatic test_midslot();
      int on_cnt, first_on, last_on, fs_cnt, bad_dark;
      logic [3:0] an_seen;
      logic [6:0] seg_seen;
      sync_frame();
      repeat (4) tick();
      disp[6:0] = 7'h3F;
      repeat (3) tick();
      checks++; if (anode !== 4'b0001 || seg !== 7'h66) begin failures++; $display("FAIL midslot_hold: anode=%b seg=%h, required 0001/66", anode, seg); end
      repeat (9) tick();
      for (int d = 1; d < 4; d++) measure_slot(on_cnt, first_on, last_on, an_seen, seg_seen, fs_cnt, bad_dark);
      measure_slot(on_cnt, first_on, last_on, an_seen, seg_seen, fs_cnt, bad_dark);
      checks++; if (seg_seen !== 7'h3F || an_seen !== 4'b0001) begin failures++; $display("FAIL midslot_next: anode=%b seg=%h, required 0001/3f", an_seen, seg_seen); end
      disp[6:0] = 7'h66;
   endtask

   task automatic test_polarity();
      rst = 1'b1;
      #1;
      checks++; if (anode_p !== 4'b1111 || seg_p !== 7'h7F) begin failures++; $display("FAIL pol_reset: anode=%b seg=%h, required 1111/7f", anode_p, seg_p); end
      tick();
      #2 rst = 1'b0;
      tick();
      checks++; if (anode_p !== 4'b1111 || seg_p !== 7'h7F || fs_p !== 1'b1 || idx_p !== 2'd0) begin
         failures++; $display("FAIL pol_guard: anode=%b seg=%h fs=%b idx=%0d, required 1111/7f/1/0", anode_p, seg_p, fs_p, idx_p);
      end
      tick();
      checks++; if (anode_p !== 4'b1110 || seg_p !== 7'h40) begin failures++; $display("FAIL pol_lit: anode=%b seg=%h, required 1110/40", anode_p, seg_p); end
   endtask

   task automatic test_reset_mid();
      int on_cnt, first_on, last_on, fs_cnt, bad_dark;
      logic [3:0] an_seen;
      logic [6:0] seg_seen;
      sync_frame();
      measure_slot(on_cnt, first_on, last_on, an_seen, seg_seen, fs_cnt, bad_dark);
      measure_slot(on_cnt, first_on, last_on, an_seen, seg_seen, fs_cnt, bad_dark);
      repeat (6) tick();
      checks++; if (anode !== 4'b0100 || digit_idx !== 2'd2) begin failures++; $display("FAIL rstmid_pre: anode=%b idx=%0d, required 0100/2", anode, digit_idx); end
      #2 rst = 1'b1;
      #1;
      checks++; if (anode !== 4'b0000 || seg !== 7'h00 || digit_idx !== 2'd0) begin failures++; $display("FAIL rstmid_async: anode=%b seg=%h idx=%0d, required 0000/00/0", anode, seg, digit_idx); end
      #2 rst = 1'b0;
      tick();
      checks++; if (frame_start !== 1'b1 || anode !== 4'b0000) begin failures++; $display("FAIL rstmid_fs: fs=%b anode=%b, required 1/0000", frame_start, anode); end
      tick();
      checks++; if (anode !== 4'b0001 || seg !== 7'h66) begin failures++; $display("FAIL rstmid_restart: anode=%b seg=%h, required 0001/66", anode, seg); end
   endtask

   task automatic test_three_digits();
      logic [2:0] exp_an  [3] = '{3'b001, 3'b010, 3'b100};
      logic [6:0] exp_seg [3] = '{7'h06, 7'h5B, 7'h4F};
      int         on_cnt  [3] = '{0, 0, 0};
      logic [2:0] an_seen [3] = '{3'b000, 3'b000, 3'b000};
      logic [6:0] seg_seen[3] = '{7'h00, 7'h00, 7'h00};
      int fs_mid = 0;
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (fs3) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin failures++; $display("FAIL three_sync: no frame_start within 100 cycles, required one pulse"); end
      checks++; if (idx3 !== 2'd0) begin failures++; $display("FAIL three_idx_start: got %0d, required 0", idx3); end
      for (int j = 1; j <= 24; j++) begin
         int s;
         tick();
         s = (j - 1) / 8;
         if (anode3 != 3'b000) begin on_cnt[s]++; an_seen[s] = anode3; seg_seen[s] = seg3; end
         if (j < 24 && fs3) fs_mid++;
         if (j == 6) begin checks++; if (idx3 !== 2'd0) begin failures++; $display("FAIL three_idx j=6: got %0d, required 0", idx3); end end
         if (j == 7) begin checks++; if (idx3 !== 2'd1) begin failures++; $display("FAIL three_idx j=7: got %0d, required 1", idx3); end end
         if (j == 15) begin checks++; if (idx3 !== 2'd2) begin failures++; $display("FAIL three_idx j=15: got %0d, required 2", idx3); end end
         if (j == 23) begin checks++; if (idx3 !== 2'd0) begin failures++; $display("FAIL three_idx j=23: got %0d, required 0", idx3); end end
      end
      checks++; if (fs3 !== 1'b1 || fs_mid != 0) begin failures++; $display("FAIL three_frame: fs=%b mid_pulses=%0d, required 1/0", fs3, fs_mid); end
      for (int s = 0; s < 3; s++) begin
         checks++; if (on_cnt[s] != 3 || an_seen[s] !== exp_an[s] || seg_seen[s] !== exp_seg[s]) begin
            failures++; $display("FAIL three_slot s=%0d: on=%0d anode=%b seg=%h, required 3/%b/%h", s, on_cnt[s], an_seen[s], seg_seen[s], exp_an[s], exp_seg[s]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_duty();
      test_blank();
      test_midslot();
      test_polarity();
      test_reset_mid();
      test_three_digits();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Parametrised time-multiplexed driver for common-anode/common-cathode 7-segment banks of any digit count. It has an internal scan prescaler, so no external divided clock is needed. It adds per-digit blanking, PWM brightness control, an anti-ghosting guard interval and selectable output polarity. The block sits between the per-digit segment decoders and the board pins, replacing the fixed two-digit mux.

## Interface
- NUM_DIGITS, 4: number of digits scanned; must be ≥ 2.
- SCAN_DIV, 1024: clk cycles per digit slot; must be a power of two and ≥ 2^BRIGHT_BITS.
- BRIGHT_BITS, 4: width of the brightness input.
- GUARD, 2: cycles at the start of each slot with all anodes off; 1 ≤ GUARD < SCAN_DIV/2^BRIGHT_BITS.
- ANODE_ACTIVE_LOW, 0: 1 means an active anode is driven 0.
- SEG_ACTIVE_LOW, 0: 1 means a lit segment is driven 0.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- disp  in  7*NUM_DIGITS  segment patterns, digit k at bits [7k+6:7k]; bit 0 is segment a. The pattern is active-high regardless of SEG_ACTIVE_LOW.
- blank  in  NUM_DIGITS  1 forces digit k dark for its slot.
- brightness  in  BRIGHT_BITS  duty level; 0 means dark.
- seg  out  7  registered segment drive, polarity per SEG_ACTIVE_LOW.
- anode  out  NUM_DIGITS  registered one-hot digit enable, polarity per ANODE_ACTIVE_LOW.
- digit_idx  out  clog2(NUM_DIGITS)  index of the slot currently being scanned.
- frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot.

## Operation
- **Prescaler `pcnt`**
  - Counts 0..SCAN_DIV-1 and wraps.
  - When `pcnt` == SCAN_DIV-1, `digit_idx` advances by one; from NUM_DIGITS-1 it wraps to 0.
- **Slot-start latch** (cycle with `pcnt` == 0): capture `disp[digit_idx]`, `blank[digit_idx]` and `brightness` into slot registers. Input changes mid-slot have no effect until the next slot.
- **Duty phase**
  - `phase` = `pcnt` >> (log2(SCAN_DIV) − BRIGHT_BITS), range 0..2^BRIGHT_BITS−1.
  - Digit on-condition, all three true:
    - `pcnt` ≥ GUARD;
    - `phase` < latched brightness;
    - latched blank == 0.
- **Output registers** (updated every cycle from the current counter state and slot registers):
  - When the on-condition holds: `anode` = one-hot(`digit_idx`) and `seg` = latched pattern.
  - Otherwise: all anodes inactive and all segments inactive.
  - Polarity inversion is applied at the register input.
- **Derived limits**
  - At most one anode is active in any cycle.
  - Maximum on-time per slot is (2^BRIGHT_BITS − 1)·SCAN_DIV/2^BRIGHT_BITS − GUARD cycles.
- **frame_start**: registered; asserted for exactly one cycle per frame of NUM_DIGITS·SCAN_DIV cycles.

## Timing
- **Reset** (asynchronous, effective immediately):
  - `pcnt` = 0, `digit_idx` = 0, slot registers = 0.
  - `seg` = all inactive (0x00, or 0x7F if SEG_ACTIVE_LOW).
  - `anode` = all inactive.
  - `frame_start` = 0.
- **After reset release**
  - First rising edge is `pcnt` = 0 of slot 0. `frame_start` rises on the following edge.
  - Earliest lit anode: one cycle after `pcnt` == GUARD.
- **Latency**: `seg`/`anode` lag `pcnt`/`digit_idx` by exactly 1 cycle.
  - `anode` always goes inactive at a slot boundary (`pcnt` = 0 < GUARD), so two digits are never on back-to-back without ≥ GUARD dark cycles.
- **Brightness edges**
  - brightness change mid-slot takes effect at the next slot start.
  - brightness = 0: the display is fully dark; counters keep running.
- **Blanking**: `blank` asserted for all digits keeps `anode` inactive; `digit_idx` and `frame_start` continue.
- **Reset mid-slot**: outputs go inactive asynchronously; scanning restarts at digit 0, `pcnt` 0.
- **NUM_DIGITS not a power of two**: `digit_idx` wraps at NUM_DIGITS−1 and never reaches unused codes.

## Test plan
Bench parameters unless stated otherwise: NUM_DIGITS=4, SCAN_DIV=16, BRIGHT_BITS=2, GUARD=1, both polarity parameters 0.

1. **Reset and scan order.** Hold rst, then release; disp = {0x06,0x5B,0x4F,0x66} (digit 3..0 order), brightness=3, blank=0.
   - `seg`=0, `anode`=0 during reset.
   - Each slot shows anode 0001/0010/0100/1000 with seg 0x66/0x4F/0x5B/0x06 in order.
   - `frame_start` pulses every 64 cycles.
2. **Duty and guard.** brightness=3: `anode` on for 11 consecutive cycles per slot (pcnt 1..11, seen 1 cycle later), dark 5.
   - brightness=1: on for 3 cycles.
   - brightness=0: `anode` stays 0 for a full frame.
3. **Blank and mid-slot changes.**
   - blank=4'b0100: the digit 2 slot shows `anode`=0 throughout while the other digits are unaffected.
   - Change disp[0] at pcnt=5 of slot 0: the new value appears only in slot 0 of the next frame.
4. **Polarity.** Set ANODE_ACTIVE_LOW=1 and SEG_ACTIVE_LOW=1.
   - Reset values are `anode`=4'b1111 and `seg`=0x7F.
   - Lit digit 0 with pattern 0x3F drives `anode`=4'b1110 and `seg`=0x40.
5. **Reset mid-operation.** Assert rst asynchronously (between clock edges) at digit 2, pcnt=7.
   - Outputs go inactive before the next edge.
   - After release, scanning restarts at digit 0 and `frame_start` fires 1 cycle after the first edge.
6. **Non-power-of-two digit count.** NUM_DIGITS=3, SCAN_DIV=8, BRIGHT_BITS=1, GUARD=1.
   - `digit_idx` sequence is 0,1,2,0.
   - Each frame is 24 cycles.
   - brightness=1 gives 3 on-cycles per slot.
   - An assertion checks ≤ 1 active anode in every cycle.
